pixel_axi4_rx: RTL and testbench

// - AXI4 read master fetching one frame-line block of grayscale pixels from memory; unpacks each DATA_W beat into GS_PXL_W pixels.
// - Streams the pixels to a downstream consumer (display/processing path) over valid/ready.
// - Read-side counterpart of the camera-path pixel AXI4 writer: same address register, same beat packing, data flows memory -> pixels.

---
 rtl/pixel_axi4_pkg.sv | 20 ++
 rtl/pixel_axi4_rx_if.sv | 33 +++
 rtl/pxl_unpack_buf.sv | 63 ++++++
 rtl/pixel_axi4_rx.sv | 139 +++++++++++++
 tb/tb_pixel_axi4_rx.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_axi4_pkg.sv
// Shared definitions for the pixel AXI4 read path.
// Contents: FSM state encoding, AXI OKAY response code, pixels-per-beat helper.
package pixel_axi4_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        AR_ST    = 2'd1,
        R_ST     = 2'd2,
        DRAIN_ST = 2'd3
    } rx_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Number of pixels carried by one data beat.
    function automatic int unsigned pxl_per_beat(input int unsigned data_w,
                                                 input int unsigned pxl_w);
        return data_w / pxl_w;
    endfunction

endpackage

// File: rtl/pixel_axi4_rx_if.sv
// AXI4 read-address and read-data channels between the pixel reader and memory.
// Signals keep the reader-side names: *_o driven by the master, *_i by the slave.
//   AR: s_arid_o, s_araddr_o, s_arlen_o, s_arvalid_o / s_arready_i
//   R : s_rid_i, s_rdata_i, s_rresp_i, s_rlast_i, s_rvalid_i / s_rready_o
interface pixel_axi4_rx_if #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned MST_ID_W     = 5,
    parameter int unsigned TRANS_RESP_W = 2,
    parameter int unsigned LEN_W        = 12
);
    logic [MST_ID_W-1:0]     s_arid_o;
    logic [ADDR_W-1:0]       s_araddr_o;
    logic [LEN_W-1:0]        s_arlen_o;
    logic                    s_arvalid_o;
    logic                    s_arready_i;
    logic [MST_ID_W-1:0]     s_rid_i;
    logic [DATA_W-1:0]       s_rdata_i;
    logic [TRANS_RESP_W-1:0] s_rresp_i;
    logic                    s_rlast_i;
    logic                    s_rvalid_i;
    logic                    s_rready_o;

    modport master (
        output s_arid_o, s_araddr_o, s_arlen_o, s_arvalid_o, s_rready_o,
        input  s_arready_i, s_rid_i, s_rdata_i, s_rresp_i, s_rlast_i, s_rvalid_i
    );

    modport slave (
        input  s_arid_o, s_araddr_o, s_arlen_o, s_arvalid_o, s_rready_o,
        output s_arready_i, s_rid_i, s_rdata_i, s_rresp_i, s_rlast_i, s_rvalid_i
    );
endinterface

// File: rtl/pxl_unpack_buf.sv
// One-beat buffer that splits a data beat into pixels, LSB pixel first.
// Ports:
//   clk, rst        clock, async active-high reset
//   i_load, i_data  load a new beat (caller only loads when o_rdy_in_c is high)
//   o_rdy_in_c      buffer can take a beat this cycle (empty or last pixel leaving)
//   o_pxl, o_vld    current pixel and valid, i_rdy consumer ready
//   o_last_pxl_c    last pixel of the held beat is handshaking this cycle
module pxl_unpack_buf
    import pixel_axi4_pkg::*;
#(
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned GS_PXL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [DATA_W-1:0]   i_data,
    output logic                o_rdy_in_c,
    output logic [GS_PXL_W-1:0] o_pxl,
    output logic                o_vld,
    input  logic                i_rdy,
    output logic                o_last_pxl_c
);
    localparam int unsigned PXL_PER_BEAT = pxl_per_beat(DATA_W, GS_PXL_W);
    localparam int unsigned PXL_IDX_W    = (PXL_PER_BEAT > 1) ? $clog2(PXL_PER_BEAT) : 1;
    localparam logic [PXL_IDX_W-1:0] LAST_IDX = PXL_IDX_W'(PXL_PER_BEAT - 1);

    logic [DATA_W-1:0]    r_data;
    logic [PXL_IDX_W-1:0] r_idx;
    logic                 r_vld;
    logic                 w_pxl_hs;
    logic                 w_last_hs;

    assign w_pxl_hs     = r_vld & i_rdy;
    assign w_last_hs    = w_pxl_hs & (r_idx == LAST_IDX);
    assign o_rdy_in_c   = ~r_vld | w_last_hs;
    assign o_last_pxl_c = w_last_hs;
    // The beat shifts down one pixel per handshake, so the output is a plain register slice.
    assign o_pxl        = r_data[GS_PXL_W-1:0];
    assign o_vld        = r_vld;

    // Beat storage, pixel index and valid flag; a load wins over draining the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_idx  <= '0;
            r_vld  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_idx  <= '0;
            r_vld  <= 1'b1;
        end else if (w_pxl_hs) begin
            r_data <= r_data >> GS_PXL_W;
            if (r_idx == LAST_IDX) begin
                r_idx <= '0;
                r_vld <= 1'b0;
            end else begin
                r_idx <= r_idx + PXL_IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_axi4_rx.sv
// AXI4 read master: fetches TX_PER_TXN beats from the configured base address
// and streams them out as GS_PXL_W grayscale pixels over valid/ready.
// Ports:
//   clk, rst                         clock, async active-high reset
//   dcr_pxl_addr_i, dcr_rd_start_i   base address and start pulse (taken in IDLE only)
//   s_axi                            AXI4 AR/R channels (master side)
//   pxl_o, pxl_vld_o, pxl_rdy_i      pixel stream
//   busy_o, done_o, err_o            status: busy, end-of-frame pulse, sticky error
module pixel_axi4_rx
    import pixel_axi4_pkg::*;
#(
    parameter int unsigned          MST_ID_W     = 5,
    parameter logic [MST_ID_W-1:0]  MST_ID       = 5'h03,
    parameter int unsigned          DATA_W       = 256,
    parameter int unsigned          ADDR_W       = 32,
    parameter int unsigned          TRANS_RESP_W = 2,
    parameter int unsigned          TX_PER_TXN   = 2400,
    parameter int unsigned          GS_PXL_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   dcr_pxl_addr_i,
    input  logic                dcr_rd_start_i,
    pixel_axi4_rx_if.master     s_axi,
    output logic [GS_PXL_W-1:0] pxl_o,
    output logic                pxl_vld_o,
    input  logic                pxl_rdy_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);
    localparam int unsigned TX_CNT_W = $clog2(TX_PER_TXN);
    localparam logic [TX_CNT_W-1:0] LAST_BEAT = TX_CNT_W'(TX_PER_TXN - 1);

    rx_state_e             r_state;
    rx_state_e             w_next_state;
    logic [ADDR_W-1:0]     r_araddr;
    logic                  r_arvalid;
    logic [TX_CNT_W-1:0]   r_beat_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_ar_hs;
    logic                  w_buf_rdy;
    logic                  w_rready;
    logic                  w_r_hs;
    logic                  w_final_beat;
    logic                  w_beat_err;
    logic                  w_last_hs;
    logic                  w_unused_rid;

    assign w_ar_hs      = r_arvalid & s_axi.s_arready_i;
    assign w_rready     = (r_state == R_ST) & w_buf_rdy;
    assign w_r_hs       = w_rready & s_axi.s_rvalid_i;
    assign w_final_beat = (r_beat_cnt == LAST_BEAT);
    // Bad response, or RLAST not lined up with the final beat.
    assign w_beat_err   = (s_axi.s_rresp_i != TRANS_RESP_W'(AXI_RESP_OKAY))
                        | (s_axi.s_rlast_i != w_final_beat);
    assign w_unused_rid = ^s_axi.s_rid_i;

    assign s_axi.s_arid_o    = MST_ID;
    assign s_axi.s_araddr_o  = r_araddr;
    assign s_axi.s_arlen_o   = LAST_BEAT;
    assign s_axi.s_arvalid_o = r_arvalid;
    assign s_axi.s_rready_o  = w_rready;

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign err_o  = r_err;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state. DRAIN_ST is left only once the done pulse is out, so a start
    // coinciding with done is still seen outside IDLE and ignored.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (dcr_rd_start_i)             w_next_state = AR_ST;
            AR_ST:    if (w_ar_hs)                    w_next_state = R_ST;
            R_ST:     if (w_r_hs && w_final_beat)     w_next_state = DRAIN_ST;
            DRAIN_ST: if (r_done)                     w_next_state = IDLE;
            default:                                  w_next_state = IDLE;
        endcase
    end

    // Registered AR request, status flags, beat counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_araddr   <= '0;
            r_arvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_arvalid <= (w_next_state == AR_ST);
            r_busy    <= (w_next_state != IDLE);
            r_done    <= (r_state == DRAIN_ST) & w_last_hs;
            if ((r_state == IDLE) && dcr_rd_start_i) begin
                r_araddr   <= dcr_pxl_addr_i;
                r_err      <= 1'b0;
                r_beat_cnt <= '0;
            end
            if (w_r_hs) begin
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
                // Saturate on the final beat instead of wrapping.
                if (!w_final_beat) begin
                    r_beat_cnt <= r_beat_cnt + TX_CNT_W'(1);
                end
            end
        end
    end

    pxl_unpack_buf #(
        .DATA_W   (DATA_W),
        .GS_PXL_W (GS_PXL_W)
    ) u_unpack_buf (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_r_hs),
        .i_data       (s_axi.s_rdata_i),
        .o_rdy_in_c   (w_buf_rdy),
        .o_pxl        (pxl_o),
        .o_vld        (pxl_vld_o),
        .i_rdy        (pxl_rdy_i),
        .o_last_pxl_c (w_last_hs)
    );

endmodule

// File: tb/tb_pixel_axi4_rx.sv
// Bench for pixel_axi4_rx with DATA_W=32, GS_PXL_W=8, TX_PER_TXN=4.
// A driver task plays the AXI slave and the pixel consumer and queues the
// expected pixel stream; a negedge monitor pops and compares every pixel
// handshake and checks RREADY against a beat/pixel count model.
module tb_pixel_axi4_rx;
    localparam int unsigned TX  = 4;
    localparam int unsigned PPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dcr_pxl_addr;
    logic        dcr_rd_start;
    logic [7:0]  pxl;
    logic        pxl_vld;
    logic        pxl_rdy;
    logic        busy, done, err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;

    logic [7:0] exp_q[$];
    int  ar_hs_total = 0;
    int  done_total  = 0;
    bit  r_phase     = 0;
    int  beats_acc   = 0;
    int  pix_del     = 0;
    bit  prev_hold   = 0;
    logic [7:0] prev_pxl = '0;

    pixel_axi4_rx_if #(.ADDR_W(32), .DATA_W(32), .MST_ID_W(5), .TRANS_RESP_W(2), .LEN_W(2)) axi ();

    pixel_axi4_rx #(
        .MST_ID_W(5), .MST_ID(5'h03), .DATA_W(32), .ADDR_W(32),
        .TRANS_RESP_W(2), .TX_PER_TXN(TX), .GS_PXL_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .dcr_pxl_addr_i(dcr_pxl_addr), .dcr_rd_start_i(dcr_rd_start),
        .s_axi(axi),
        .pxl_o(pxl), .pxl_vld_o(pxl_vld), .pxl_rdy_i(pxl_rdy),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pixel scoreboard, pixel hold-stability and RREADY model.
    always @(negedge clk) begin
        bit pxl_hs;
        bit exp_rr;
        logic [7:0] e;
        if (rst) begin
            r_phase   = 0;
            beats_acc = 0;
            pix_del   = 0;
            prev_hold = 0;
        end else begin
            pxl_hs = pxl_vld && pxl_rdy;
            exp_rr = r_phase && ((pix_del == beats_acc * PPB) ||
                                 (pxl_hs && (pix_del % PPB == PPB - 1)));
            chk(axi.s_rready_o == exp_rr, "rready", 64'(axi.s_rready_o), 64'(exp_rr));
            if (prev_hold)
                chk(pxl_vld && pxl == prev_pxl, "pxl_stable", {pxl_vld, pxl}, {1'b1, prev_pxl});
            if (pxl_hs) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "pxl_extra", 64'(pxl), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk(pxl == e, "pxl_data", 64'(pxl), 64'(e));
                end
                pix_del++;
            end
            if (axi.s_arvalid_o && axi.s_arready_i) begin
                ar_hs_total++;
                r_phase   = 1;
                beats_acc = 0;
                pix_del   = 0;
            end
            if (axi.s_rvalid_i && axi.s_rready_o) begin
                beats_acc++;
                if (beats_acc == TX) r_phase = 0;
            end
            if (done) done_total++;
            prev_hold = pxl_vld && !pxl_rdy;
            prev_pxl  = pxl;
        end
    end

    // One full read. Starts and ends at posedge+1.
    task automatic run_txn(input logic [31:0] addr, input bit pattern, input int ar_stall,
                           input bit rnd_rdy, input bit rnd_rv, input int bad_resp_beat,
                           input int bad_last_beat, input int rst_beat, input bit busy_start,
                           input bit done_start, input bit chk_lat);
        logic [31:0] beats [TX];
        int b, cyc, ar_before, t_first, t_done;
        bit err_exp, seen_arv, first, hs;
        ar_before = ar_hs_total;
        for (int i = 0; i < TX; i++) begin
            beats[i] = pattern ? (32'h03020100 + 32'h04040404 * 32'(i)) : $urandom;
            for (int k = 0; k < PPB; k++) exp_q.push_back(8'(beats[i] >> (8 * k)));
        end
        dcr_pxl_addr = addr;
        dcr_rd_start = 1'b1;
        @(posedge clk); #1;
        dcr_rd_start = 1'b0;

        // AR phase; during a stall, R data is already offered and must not be taken.
        cyc = 0; seen_arv = 0;
        axi.s_rvalid_i = (ar_stall > 0);
        axi.s_rdata_i  = beats[0];
        axi.s_rresp_i  = 2'b00;
        axi.s_rlast_i  = 1'b0;
        forever begin
            axi.s_arready_i = (cyc >= ar_stall);
            @(negedge clk);
            if (seen_arv) chk(axi.s_arvalid_o, "arvalid_hold", 64'(axi.s_arvalid_o), 64'(1));
            if (axi.s_arvalid_o) begin
                seen_arv = 1;
                chk(axi.s_araddr_o == addr, "araddr", 64'(axi.s_araddr_o), 64'(addr));
                chk(axi.s_arlen_o == 2'd3, "arlen", 64'(axi.s_arlen_o), 64'(3));
                chk(axi.s_arid_o == 5'h03, "arid", 64'(axi.s_arid_o), 64'(3));
                chk(!err, "err_cleared", 64'(err), 64'(0));
            end
            if (axi.s_arvalid_o && axi.s_arready_i) break;
            cyc++;
            if (cyc > 100) begin
                chk(1'b0, "ar_timeout", 64'(cyc), 64'(100));
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        axi.s_arready_i = 1'b0;

        // R phase.
        b = 0; cyc = 0; err_exp = 0; t_first = -1; first = 1;
        while (b < TX) begin
            if (!axi.s_rvalid_i) axi.s_rvalid_i = rnd_rv ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.s_rdata_i = beats[b];
            axi.s_rresp_i = (b == bad_resp_beat) ? 2'b10 : 2'b00;
            axi.s_rlast_i = (b == TX - 1) ^ (b == bad_last_beat);
            pxl_rdy       = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            dcr_rd_start  = busy_start && (b == 1);
            dcr_pxl_addr  = (busy_start && b == 1) ? ~addr : addr;
            hs = 0;
            @(negedge clk);
            if (first) chk(!axi.s_arvalid_o, "arvalid_drop", 64'(axi.s_arvalid_o), 64'(0));
            first = 0;
            chk(err == err_exp, "err_r", 64'(err), 64'(err_exp));
            chk(axi.s_araddr_o == addr, "araddr_hold", 64'(axi.s_araddr_o), 64'(addr));
            if (axi.s_rvalid_i && axi.s_rready_o) begin
                if (t_first < 0) t_first = cyc_n;
                if (axi.s_rresp_i != 2'b00 || axi.s_rlast_i != (b == TX - 1)) err_exp = 1;
                b++;
                hs = 1;
            end
            cyc++;
            if (cyc > 500) begin
                chk(1'b0, "r_timeout", 64'(b), 64'(TX));
                return;
            end
            @(posedge clk); #1;
            if (hs) axi.s_rvalid_i = 1'b0;
            if (rst_beat >= 0 && b == rst_beat) begin
                rst = 1'b1;
                axi.s_rvalid_i = 1'b1;
                pxl_rdy = 1'b1;
                dcr_rd_start = 1'b0;
                @(negedge clk);
                chk(!axi.s_arvalid_o, "rst_arvalid", 64'(axi.s_arvalid_o), 64'(0));
                chk(!axi.s_rready_o, "rst_rready", 64'(axi.s_rready_o), 64'(0));
                chk({pxl_vld, pxl} == 9'd0, "rst_pxl", {pxl_vld, pxl}, 64'(0));
                chk({busy, done, err} == 3'b000, "rst_status", {busy, done, err}, 64'(0));
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                chk(!axi.s_rready_o && !busy, "post_rst_idle", {axi.s_rready_o, busy}, 64'(0));
                @(posedge clk); #1;
                axi.s_rvalid_i = 1'b0;
                return;
            end
        end
        axi.s_rvalid_i = 1'b0;
        dcr_rd_start   = 1'b0;
        dcr_pxl_addr   = addr;

        // Drain until the done pulse.
        cyc = 0;
        forever begin
            pxl_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk(err == err_exp, "err_drain", 64'(err), 64'(err_exp));
            if (done) break;
            cyc++;
            if (cyc > 300) begin
                chk(1'b0, "done_timeout", 64'(exp_q.size()), 64'(0));
                return;
            end
            @(posedge clk); #1;
        end
        t_done = cyc_n;
        chk(exp_q.size() == 0, "pxl_count", 64'(exp_q.size()), 64'(0));
        if (chk_lat) chk(t_done - t_first == 17, "done_latency", 64'(t_done - t_first), 64'(17));
        if (done_start) dcr_rd_start = 1'b1;
        @(posedge clk); #1;
        dcr_rd_start = 1'b0;
        pxl_rdy = 1'b0;
        @(negedge clk);
        chk(!done, "done_one_cycle", 64'(done), 64'(0));
        for (int i = 0; i < 3; i++) begin
            chk(!busy && !axi.s_arvalid_o, "idle_after_done", {busy, axi.s_arvalid_o}, 64'(0));
            @(negedge clk);
        end
        chk(ar_hs_total - ar_before == 1, "ar_count", 64'(ar_hs_total - ar_before), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        dcr_pxl_addr = '0;
        dcr_rd_start = 1'b0;
        pxl_rdy = 1'b0;
        axi.s_arready_i = 1'b0;
        axi.s_rid_i     = 5'h1F;
        axi.s_rdata_i   = '0;
        axi.s_rresp_i   = 2'b00;
        axi.s_rlast_i   = 1'b0;
        axi.s_rvalid_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(!axi.s_arvalid_o && !axi.s_rready_o, "reset_axi", {axi.s_arvalid_o, axi.s_rready_o}, 64'(0));
        chk({pxl_vld, pxl} == 9'd0, "reset_pxl", {pxl_vld, pxl}, 64'(0));
        chk({busy, done, err} == 3'b000, "reset_status", {busy, done, err}, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic pattern read at full throughput.
        d0 = done_total;
        run_txn(32'h1000_0000, 1, 0, 0, 0, -1, -1, -1, 0, 0, 1);
        chk(done_total - d0 == 1, "done_count", 64'(done_total - d0), 64'(1));
        // AR stall for 10 cycles.
        run_txn(32'h2000_0040, 0, 10, 0, 0, -1, -1, -1, 0, 0, 0);
        // Random backpressure and R gaps, with a start pulse while busy.
        for (int i = 0; i < 3; i++)
            run_txn($urandom, 0, int'($urandom_range(0, 3)), 1, 1, -1, -1, -1, 1, 0, 0);
        // Error response on beat 1, still delivering all pixels.
        run_txn(32'h3000_0000, 0, 0, 1, 0, 1, -1, -1, 0, 0, 0);
        // Early RLAST on beat 2, plus a start in the done cycle.
        run_txn(32'h3000_1000, 0, 1, 0, 1, -1, 2, -1, 0, 1, 0);
        // Missing RLAST on the final beat.
        run_txn(32'h3000_2000, 0, 0, 1, 1, -1, 3, -1, 0, 0, 0);
        // Clean read clears the error.
        run_txn(32'h4000_0000, 0, 0, 0, 0, -1, -1, -1, 0, 0, 1);
        // Reset after beat 1, then a clean full read.
        run_txn(32'h5000_0000, 0, 0, 1, 0, -1, -1, 2, 0, 0, 0);
        run_txn(32'h5000_0100, 1, 0, 0, 0, -1, -1, -1, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
